// File: rtl/rand_pkg.sv
// rand_pkg: shared state encoding and sample width for the random draw scheduler
package rand_pkg;
    localparam int RAND_W = 32;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_COOL = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
endpackage

// File: rtl/rr_arbiter_comb.sv
// rr_arbiter_comb: rotate-priority encoder picking the first request at or after rr_ptr
module rr_arbiter_comb
    import rand_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [ID_W-1:0]    win_id
);
    // scan offsets from farthest to nearest so the nearest asserted request wins
    always_comb begin
        logic [ID_W:0] s;
        logic [ID_W:0] k;
        win = '0;
        win_id = '0;
        s = '0;
        k = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            s = {1'b0, rr_ptr} + (ID_W + 1)'(i);
            k = (s >= (ID_W + 1)'(NUM_REQ)) ? s - (ID_W + 1)'(NUM_REQ) : s;
            if (req[k[ID_W-1:0]]) begin
                win = '0;
                win[k[ID_W-1:0]] = 1'b1;
                win_id = k[ID_W-1:0];
            end
        end
    end
endmodule

// File: rtl/rand_draw_scheduler.sv
// rand_draw_scheduler: shares one LFSR sample stream among requesters with spaced draws and reseed flush
module rand_draw_scheduler
    import rand_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GAP = 4,
    parameter int CNT_W = 16,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [RAND_W-1:0] rand_in,
    input  logic [NUM_REQ-1:0] req,
    input  logic              reseed,
    output logic [NUM_REQ-1:0] ack,
    output logic [RAND_W-1:0] rand_out,
    output logic              rand_valid,
    output logic [ID_W-1:0]   grant_id,
    output logic              gen_reset,
    output logic              busy,
    output logic [CNT_W-1:0]  draw_count
);
    localparam int GAP_W = $clog2(GAP + 1);

    logic [1:0]         state;
    logic [GAP_W-1:0]   gap_cnt;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    win_id;
    logic [NUM_REQ-1:0] win;

    rr_arbiter_comb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req(req),
        .rr_ptr(rr_ptr),
        .win(win),
        .win_id(win_id)
    );

    assign busy = (state != S_IDLE);

    // reseed beats grants; grants only from IDLE; COOL and FLUSH share one countdown back to IDLE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            gap_cnt <= '0;
            rr_ptr <= '0;
            ack <= '0;
            rand_out <= '0;
            rand_valid <= 1'b0;
            grant_id <= '0;
            gen_reset <= 1'b0;
            draw_count <= '0;
        end else begin
            ack <= '0;
            rand_valid <= 1'b0;
            gen_reset <= 1'b0;
            if (reseed) begin
                gen_reset <= 1'b1;
                gap_cnt <= GAP_W'(GAP);
                state <= S_FLUSH;
            end else if (state == S_IDLE) begin
                if (|req) begin
                    ack <= win;
                    rand_valid <= 1'b1;
                    rand_out <= rand_in;
                    grant_id <= win_id;
                    rr_ptr <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
                    draw_count <= draw_count + 1'b1;
                    gap_cnt <= GAP_W'(GAP - 1);
                    state <= (GAP == 1) ? S_IDLE : S_COOL;
                end
            end else begin
                gap_cnt <= gap_cnt - 1'b1;
                state <= (gap_cnt <= GAP_W'(1)) ? S_IDLE : state;
            end
        end
    end
endmodule

// File: tb/tb_rand_draw_scheduler.sv
// tb_rand_draw_scheduler: directed tests of arbitration, spacing, reseed flush and reset
module tb_rand_draw_scheduler;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [31:0] rand_in = 32'd1;
    logic [3:0] req = '0;
    logic reseed = 1'b0;
    logic [3:0] ack;
    logic [31:0] rand_out;
    logic rand_valid;
    logic [1:0] grant_id;
    logic gen_reset;
    logic busy;
    logic [15:0] draw_count;

    logic [2:0] req2 = '0;
    logic reseed2 = 1'b0;
    logic [2:0] ack2;
    logic [31:0] rand_out2;
    logic rand_valid2;
    logic [1:0] grant_id2;
    logic gen_reset2;
    logic busy2;
    logic [1:0] draw_count2;

    int ecnt = 0;
    int n_checks = 0;
    int n_fail = 0;

    rand_draw_scheduler #(.NUM_REQ(4), .GAP(4), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .rand_in(rand_in), .req(req), .reseed(reseed),
        .ack(ack), .rand_out(rand_out), .rand_valid(rand_valid), .grant_id(grant_id),
        .gen_reset(gen_reset), .busy(busy), .draw_count(draw_count)
    );

    rand_draw_scheduler #(.NUM_REQ(3), .GAP(1), .CNT_W(2)) dut_small (
        .clock(clock), .reset(reset), .rand_in(rand_in), .req(req2), .reseed(reseed2),
        .ack(ack2), .rand_out(rand_out2), .rand_valid(rand_valid2), .grant_id(grant_id2),
        .gen_reset(gen_reset2), .busy(busy2), .draw_count(draw_count2)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        ecnt <= ecnt + 1;
        rand_in <= rand_in + 32'd1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        req2 = '0;
        reseed = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_checks++;
        if (ack !== 4'b0000 || rand_valid !== 1'b0 || gen_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: ack=%b rand_valid=%b gen_reset=%b required 0000 0 0", ack, rand_valid, gen_reset);
        end
        n_checks++;
        if (rand_out !== 32'd0 || grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_data: rand_out=%0d grant_id=%0d required 0 0", rand_out, grant_id);
        end
        n_checks++;
        if (busy !== 1'b0 || draw_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_status: busy=%b draw_count=%0d required 0 0", busy, draw_count);
        end
        do_reset();
    endtask

    task automatic test_single();
        int g;
        do_reset();
        req = 4'b0100;
        tick(1);
        g = ecnt;
        n_checks++;
        if (ack !== 4'b0100 || rand_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ack: ack=%b rand_valid=%b required 0100 1", ack, rand_valid);
        end
        n_checks++;
        if (rand_out !== 32'(g) || grant_id !== 2'd2 || draw_count !== 16'd1) begin
            n_fail++;
            $display("FAIL single_data: rand_out=%0d grant_id=%0d draw_count=%0d required %0d 2 1", rand_out, grant_id, draw_count, g);
        end
        req = 4'b0000;
        tick(1);
        n_checks++;
        if (ack !== 4'b0000 || rand_valid !== 1'b0 || rand_out !== 32'(g) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_hold: ack=%b rand_valid=%b rand_out=%0d busy=%b required 0000 0 %0d 1", ack, rand_valid, rand_out, busy, g);
        end
        tick(2);
        n_checks++;
        if (busy !== 1'b0 || grant_id !== 2'd2) begin
            n_fail++;
            $display("FAIL single_cool_end: busy=%b grant_id=%0d required 0 2", busy, grant_id);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        k = 0;
        do_reset();
        req = 4'b1111;
        for (int i = 1; i <= 17; i++) begin
            tick(1);
            if ((i - 1) % 4 == 0) begin
                n_checks++;
                if (ack !== (4'b0001 << (k % 4)) || grant_id !== 2'(k % 4) || rand_valid !== 1'b1 || rand_out !== 32'(ecnt)) begin
                    n_fail++;
                    $display("FAIL rr_grant%0d: ack=%b grant_id=%0d valid=%b rand_out=%0d required %b %0d 1 %0d", k, ack, grant_id, rand_valid, rand_out, 4'b0001 << (k % 4), k % 4, ecnt);
                end
                k++;
            end else begin
                n_checks++;
                if (ack !== 4'b0000 || rand_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rr_gap_cycle%0d: ack=%b rand_valid=%b required 0000 0", i, ack, rand_valid);
                end
            end
        end
        n_checks++;
        if (draw_count !== 16'd5) begin
            n_fail++;
            $display("FAIL rr_count: draw_count=%0d required 5", draw_count);
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 4'b1011;
        tick(1);
        n_checks++;
        if (ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL wd_first: ack=%b required 0001", ack);
        end
        req = 4'b1010;
        tick(1);
        req = 4'b1000;
        tick(2);
        n_checks++;
        if (ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL wd_cool: ack=%b required 0000", ack);
        end
        tick(1);
        n_checks++;
        if (ack !== 4'b1000 || grant_id !== 2'd3) begin
            n_fail++;
            $display("FAIL wd_grant: ack=%b grant_id=%0d required 1000 3", ack, grant_id);
        end
        req = 4'b0011;
        tick(4);
        n_checks++;
        if (ack !== 4'b0001 || grant_id !== 2'd0 || draw_count !== 16'd3) begin
            n_fail++;
            $display("FAIL wd_wrap: ack=%b grant_id=%0d draw_count=%0d required 0001 0 3", ack, grant_id, draw_count);
        end
        req = 4'b0000;
    endtask

    task automatic test_reseed();
        do_reset();
        req = 4'b0001;
        reseed = 1'b1;
        tick(1);
        reseed = 1'b0;
        n_checks++;
        if (gen_reset !== 1'b1 || ack !== 4'b0000 || busy !== 1'b1 || draw_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reseed_pulse: gen_reset=%b ack=%b busy=%b draw_count=%0d required 1 0000 1 0", gen_reset, ack, busy, draw_count);
        end
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            n_checks++;
            if (ack !== 4'b0000 || gen_reset !== 1'b0 || busy !== (i < 4)) begin
                n_fail++;
                $display("FAIL reseed_flush%0d: ack=%b gen_reset=%b busy=%b required 0000 0 %b", i, ack, gen_reset, busy, i < 4);
            end
        end
        tick(1);
        n_checks++;
        if (ack !== 4'b0001 || rand_out !== 32'(ecnt) || draw_count !== 16'd1) begin
            n_fail++;
            $display("FAIL reseed_grant: ack=%b rand_out=%0d draw_count=%0d required 0001 %0d 1", ack, rand_out, draw_count, ecnt);
        end
        req = 4'b0000;
    endtask

    task automatic test_reseed_restart();
        do_reset();
        reseed = 1'b1;
        tick(1);
        reseed = 1'b0;
        tick(1);
        reseed = 1'b1;
        tick(1);
        reseed = 1'b0;
        req = 4'b0001;
        n_checks++;
        if (gen_reset !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_pulse: gen_reset=%b busy=%b required 1 1", gen_reset, busy);
        end
        tick(4);
        n_checks++;
        if (ack !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_flush: ack=%b busy=%b required 0000 0", ack, busy);
        end
        tick(1);
        n_checks++;
        if (ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL restart_grant: ack=%b required 0001", ack);
        end
        req = 4'b0000;
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b1111;
        tick(2);
        #2;
        reset = 1'b1;
        req = 4'b1010;
        #1;
        n_checks++;
        if (busy !== 1'b0 || draw_count !== 16'd0 || grant_id !== 2'd0 || rand_out !== 32'd0 || ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_clear: busy=%b draw_count=%0d grant_id=%0d rand_out=%0d ack=%b required 0 0 0 0 0000", busy, draw_count, grant_id, rand_out, ack);
        end
        #1;
        reset = 1'b0;
        tick(1);
        n_checks++;
        if (ack !== 4'b0010 || grant_id !== 2'd1 || draw_count !== 16'd1) begin
            n_fail++;
            $display("FAIL async_regrant: ack=%b grant_id=%0d draw_count=%0d required 0010 1 1", ack, grant_id, draw_count);
        end
        req = 4'b0000;
    endtask

    task automatic test_count_wrap();
        do_reset();
        req2 = 3'b111;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            n_checks++;
            if (ack2 !== (3'b001 << (i % 3)) || draw_count2 !== 2'((i + 1) % 4) || rand_valid2 !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_grant%0d: ack=%b draw_count=%0d valid=%b required %b %0d 1", i, ack2, draw_count2, rand_valid2, 3'b001 << (i % 3), (i + 1) % 4);
            end
        end
        n_checks++;
        if (busy2 !== 1'b0 || grant_id2 !== 2'd2) begin
            n_fail++;
            $display("FAIL wrap_status: busy=%b grant_id=%0d required 0 2", busy2, grant_id2);
        end
        req2 = 3'b000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_withdraw();
        test_reseed();
        test_reseed_restart();
        test_async_reset();
        test_count_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
